// File: rtl/pool_gb_rsp.sv
// pool_gb_rsp: global-buffer-side read responder for the POOL block.
// Queues POOL reads and shares a single-port GB SRAM with a write port.
module pool_gb_rsp #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 96,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1,
    parameter int WR_STARVE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              POOLGB_rdy,
    input  logic [ADDR_W-1:0] POOLGB_addr,
    input  logic              POOLGB_fnh,
    output logic              GBPOOL_val,
    output logic [DATA_W-1:0] GBPOOL_data,
    output logic              GBPOOL_done,
    output logic              GBPOOL_ovf,
    input  logic              wr_val,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_rdy,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int QC_W  = PTR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam int STV_W = $clog2(WR_STARVE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [ADDR_W-1:0] q_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [QC_W-1:0]   q_cnt;
    logic              q_empty;
    logic              q_full;
    logic              push;
    logic              pop;
    logic              wr_grant;
    logic [STV_W-1:0]  starve_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  out_cnt_nxt;
    logic              done_nxt;
    state_t            state;
    state_t            state_nxt;

    assign q_empty  = (q_cnt == '0);
    assign q_full   = (q_cnt == QC_W'(FIFO_DEPTH));
    assign wr_grant = wr_val & ((starve_cnt < STV_W'(WR_STARVE)) | q_empty);
    assign pop      = ~wr_grant & ~q_empty;
    assign push     = POOLGB_rdy & (~q_full | pop);
    assign wr_rdy   = wr_grant;

    assign out_cnt_nxt = out_cnt + CNT_W'(push) - CNT_W'(GBPOOL_val);

    // Drive the shared SRAM port from the arbiter decision.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (wr_grant) begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = wr_addr;
            sram_wdata = wr_data;
        end else if (pop) begin
            sram_cs   = 1'b1;
            sram_addr = q_mem[rd_ptr];
        end
    end

    // Request queue storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= POOLGB_addr;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + QC_W'(1);
                2'b01:   q_cnt <= q_cnt - QC_W'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Count write grants that bypass a waiting read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (q_empty || pop) begin
            starve_cnt <= '0;
        end else if (wr_grant) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Sticky overflow when a request is dropped on a full queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            GBPOOL_ovf <= 1'b0;
        end else if (POOLGB_rdy && q_full && !pop) begin
            GBPOOL_ovf <= 1'b1;
        end
    end

    // Track issued reads and register returning SRAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe    <= '0;
            GBPOOL_val  <= 1'b0;
            GBPOOL_data <= '0;
        end else begin
            vld_pipe   <= (vld_pipe << 1) | RD_LAT'(pop);
            GBPOOL_val <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1]) begin
                GBPOOL_data <= sram_rdata;
            end
        end
    end

    // Outstanding requests: queued, in flight or awaiting return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_nxt;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame next state; drain ends once only the return in the output stage remains.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (push && POOLGB_fnh) begin
                    state_nxt = DRAIN;
                end else if (push) begin
                    state_nxt = SERVE;
                end else if (POOLGB_fnh) begin
                    state_nxt = DONE;
                end
            end
            SERVE: begin
                if (POOLGB_fnh) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt_nxt == CNT_W'(vld_pipe[RD_LAT-1])) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = push ? SERVE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame outputs.
    always_comb begin
        done_nxt = (state == DONE);
    end

    // Register the done pulse so it trails the final return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            GBPOOL_done <= 1'b0;
        end else begin
            GBPOOL_done <= done_nxt;
        end
    end

endmodule
